// File: rtl/opram_wr_sched_if.sv
// Bus between the busy-table write scheduler and its environment:
// set/clear requests, RAM write port, read forwarding and status.
interface opram_wr_sched_if #(
  parameter int NREQ = 2,
  parameter int NRD  = 7
);
  logic              flush_i;
  logic [NREQ-1:0]   set_valid_i;
  logic [NREQ*6-1:0] set_addr_i;
  logic [NREQ-1:0]   set_ready_o;
  logic              clr_valid_i;
  logic [5:0]        clr_addr_i;
  logic              clr_ready_o;
  logic              ram_we_o;
  logic [5:0]        ram_aw_o;
  logic              ram_di_o;
  logic [NRD*6-1:0]  rd_addr_i;
  logic [NRD-1:0]    ram_q_i;
  logic [NRD-1:0]    rd_q_o;
  logic              init_done_o;
  logic [2:0]        fifo_cnt_o;

  modport master (
    output flush_i, set_valid_i, set_addr_i,
    output clr_valid_i, clr_addr_i,
    output rd_addr_i, ram_q_i,
    input  set_ready_o, clr_ready_o,
    input  ram_we_o, ram_aw_o, ram_di_o,
    input  rd_q_o, init_done_o, fifo_cnt_o
  );

  modport slave (
    input  flush_i, set_valid_i, set_addr_i,
    input  clr_valid_i, clr_addr_i,
    input  rd_addr_i, ram_q_i,
    output set_ready_o, clr_ready_o,
    output ram_we_o, ram_aw_o, ram_di_o,
    output rd_q_o, init_done_o, fifo_cnt_o
  );
endinterface

// File: rtl/opram_wr_sched.sv
// Write-port scheduler for the 64x1 operand-ready RAM (busy table).
// Optional WSCHED_COALESCE_EN: duplicate sets are accepted but not queued.
module opram_wr_sched #(
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int NRD        = 7
) (
  input logic             clk,
  input logic             rst_n,
  opram_wr_sched_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nx;
  logic [5:0]      sweep;
  logic [5:0]      q_addr    [FIFO_DEPTH];
  logic [5:0]      q_addr_nx [FIFO_DEPTH];
  logic [CW-1:0]   cnt, cnt_nx;
  logic            run, acc_en, pop, kill;
  logic [NREQ-1:0] ready, enq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_nx;
      sweep <= (bus.flush_i || state == RUN) ? 6'd0 : sweep + 6'd1;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.flush_i)
      state_nx = INIT;
    else if (state == INIT && sweep == 6'd63)
      state_nx = RUN;
  end

  always_comb begin
    run             = (state == RUN);
    acc_en          = run & ~bus.flush_i;
    bus.init_done_o = run;
    bus.clr_ready_o = acc_en;
    bus.ram_we_o    = 1'b0;
    bus.ram_aw_o    = '0;
    bus.ram_di_o    = 1'b0;
    if (!run) begin
      bus.ram_we_o = 1'b1;
      bus.ram_aw_o = sweep;
      bus.ram_di_o = 1'b1;
    end else if (bus.clr_valid_i) begin
      bus.ram_we_o = 1'b1;
      bus.ram_aw_o = bus.clr_addr_i;
    end else if (cnt != '0) begin
      bus.ram_we_o = 1'b1;
      bus.ram_aw_o = q_addr[0];
      bus.ram_di_o = 1'b1;
    end
  end

  assign pop  = run & ~bus.clr_valid_i & (cnt != '0);
  assign kill = acc_en & bus.clr_valid_i;

  // Slots are granted on the pre-pop count; coalesced sets take no slot.
  always_comb begin
    int         free, used;
    logic [5:0] a;
    logic       coal;
    ready = '0;
    enq   = '0;
    free  = FIFO_DEPTH - int'(cnt);
    used  = 0;
    for (int k = 0; k < NREQ; k++) begin
      a    = bus.set_addr_i[k*6 +: 6];
      coal = 1'b0;
`ifdef WSCHED_COALESCE_EN
      for (int e = 0; e < FIFO_DEPTH; e++)
        if (e < int'(cnt) && q_addr[e] == a) coal = 1'b1;
      for (int m = 0; m < k; m++)
        if (ready[m] && bus.set_valid_i[m] &&
            bus.set_addr_i[m*6 +: 6] == a) coal = 1'b1;
      coal = coal & bus.set_valid_i[k];
`endif
      if (acc_en)
        ready[k] = coal ? (free > 0) : (free > used);
      enq[k] = ready[k] & bus.set_valid_i[k] & ~coal;
      if (bus.set_valid_i[k] && !coal) used++;
    end
  end

  assign bus.set_ready_o = ready;

  // Queue stays compacted: survivors first, then new sets in index order.
  always_comb begin
    int         j;
    logic [5:0] a;
    q_addr_nx = q_addr;
    j = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (i < int'(cnt) && !(pop && i == 0) &&
          !(kill && q_addr[i] == bus.clr_addr_i)) begin
        q_addr_nx[j] = q_addr[i];
        j++;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      a = bus.set_addr_i[k*6 +: 6];
      if (enq[k] && !(kill && a == bus.clr_addr_i) && j < FIFO_DEPTH) begin
        q_addr_nx[j] = a;
        j++;
      end
    end
    cnt_nx = CW'(j);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (bus.flush_i)
      cnt <= '0;
    else
      cnt <= cnt_nx;
  end

  always_ff @(posedge clk) begin
    q_addr <= q_addr_nx;
  end

  assign bus.fifo_cnt_o = 3'(cnt);

  always_comb begin
    logic hit;
    bus.rd_q_o = '0;
    for (int i = 0; i < NRD; i++) begin
      hit = 1'b0;
      for (int e = 0; e < FIFO_DEPTH; e++)
        if (e < int'(cnt) && q_addr[e] == bus.rd_addr_i[i*6 +: 6])
          hit = 1'b1;
      bus.rd_q_o[i] = ~run | bus.ram_q_i[i] | hit;
    end
  end
endmodule

// File: tb/tb_opram_wr_sched.sv
// Random-stimulus bench for opram_wr_sched against a queue-based model.
// A behavioural 64x1 RAM sits on the write/read ports.
module tb_opram_wr_sched;
  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int NRD   = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  opram_wr_sched_if #(.NREQ(NREQ), .NRD(NRD)) bus ();

  opram_wr_sched #(
    .NREQ(NREQ), .FIFO_DEPTH(DEPTH), .NRD(NRD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic ram [64];

  always @(posedge clk)
    if (bus.ram_we_o) ram[bus.ram_aw_o] <= bus.ram_di_o;

  always_comb begin
    bus.ram_q_i = '0;
    for (int i = 0; i < NRD; i++)
      bus.ram_q_i[i] = ram[bus.rd_addr_i[i*6 +: 6]];
  end

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit         m_init;
  int         m_sweep;
  logic [5:0] mq [$];
  int         mode;

  function automatic logic [5:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return 6'($urandom_range(0, 7));
  endfunction

  task automatic drive_rand();
    bus.flush_i = ($urandom_range(0, 299) == 0);
    case (mode)
      0:       bus.clr_valid_i = ($urandom_range(0, 7) == 0);
      1:       bus.clr_valid_i = ($urandom_range(0, 1) == 0);
      default: bus.clr_valid_i = ($urandom_range(0, 3) != 0);
    endcase
    bus.clr_addr_i  = rand_addr();
    bus.set_valid_i = NREQ'($urandom_range(0, 3));
    for (int k = 0; k < NREQ; k++)
      bus.set_addr_i[k*6 +: 6] = rand_addr();
    for (int i = 0; i < NRD; i++)
      bus.rd_addr_i[i*6 +: 6] = rand_addr();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},   64'(bus.ram_we_o), 64'd1);
    check({tag, "_aw"},   64'(bus.ram_aw_o), 64'd0);
    check({tag, "_di"},   64'(bus.ram_di_o), 64'd1);
    check({tag, "_srdy"}, 64'(bus.set_ready_o), 64'd0);
    check({tag, "_crdy"}, 64'(bus.clr_ready_o), 64'd0);
    check({tag, "_done"}, 64'(bus.init_done_o), 64'd0);
    check({tag, "_cnt"},  64'(bus.fifo_cnt_o), 64'd0);
    check({tag, "_rdq"},  64'(bus.rd_q_o), 64'h7F);
  endtask

  task automatic model_step();
    logic [NREQ-1:0] e_rdy;
    logic [NRD-1:0]  e_q;
    bit              coal [NREQ];
    bit              e_we, e_di, hit;
    logic [5:0]      e_aw, a, clr;
    logic [5:0]      keep [$];
    int              free, used;

    clr  = bus.clr_addr_i;
    e_we = 1'b0;
    e_aw = '0;
    e_di = 1'b0;
    if (m_init) begin
      e_we = 1'b1; e_aw = 6'(m_sweep); e_di = 1'b1;
    end else if (bus.clr_valid_i) begin
      e_we = 1'b1; e_aw = clr; e_di = 1'b0;
    end else if (mq.size() > 0) begin
      e_we = 1'b1; e_aw = mq[0]; e_di = 1'b1;
    end
    check("we", 64'(bus.ram_we_o), 64'(e_we));
    if (e_we) begin
      check("aw", 64'(bus.ram_aw_o), 64'(e_aw));
      check("di", 64'(bus.ram_di_o), 64'(e_di));
    end
    check("init_done", 64'(bus.init_done_o), 64'(!m_init));
    check("clr_ready", 64'(bus.clr_ready_o),
          64'(!m_init && !bus.flush_i));
    check("fifo_cnt", 64'(bus.fifo_cnt_o), 64'(mq.size()));

    e_rdy = '0;
    free  = DEPTH - mq.size();
    used  = 0;
    for (int k = 0; k < NREQ; k++) begin
      a = bus.set_addr_i[k*6 +: 6];
      coal[k] = 1'b0;
`ifdef WSCHED_COALESCE_EN
      if (bus.set_valid_i[k]) begin
        foreach (mq[e]) if (mq[e] == a) coal[k] = 1'b1;
        for (int m = 0; m < k; m++)
          if (e_rdy[m] && bus.set_valid_i[m] &&
              bus.set_addr_i[m*6 +: 6] == a) coal[k] = 1'b1;
      end
`endif
      if (!m_init && !bus.flush_i)
        e_rdy[k] = coal[k] ? (mq.size() < DEPTH) : (free > used);
      if (bus.set_valid_i[k] && !coal[k]) used++;
    end
    check("set_ready", 64'(bus.set_ready_o), 64'(e_rdy));

    for (int i = 0; i < NRD; i++) begin
      a   = bus.rd_addr_i[i*6 +: 6];
      hit = 1'b0;
      foreach (mq[e]) if (mq[e] == a) hit = 1'b1;
      e_q[i] = m_init | bus.ram_q_i[i] | hit;
    end
    check("rd_q", 64'(bus.rd_q_o), 64'(e_q));

    if (bus.flush_i) begin
      m_init = 1'b1; m_sweep = 0; mq.delete();
    end else if (m_init) begin
      if (m_sweep == 63) begin m_init = 1'b0; m_sweep = 0; end
      else m_sweep++;
    end else begin
      if (!bus.clr_valid_i && mq.size() > 0) void'(mq.pop_front());
      for (int k = 0; k < NREQ; k++)
        if (e_rdy[k] && bus.set_valid_i[k] && !coal[k])
          mq.push_back(bus.set_addr_i[k*6 +: 6]);
      if (bus.clr_valid_i) begin
        keep = {};
        foreach (mq[e]) if (mq[e] != clr) keep.push_back(mq[e]);
        mq = keep;
      end
    end
  endtask

  initial begin
    bus.flush_i     = 1'b0;
    bus.set_valid_i = '0;
    bus.set_addr_i  = '0;
    bus.clr_valid_i = 1'b0;
    bus.clr_addr_i  = '0;
    bus.rd_addr_i   = '0;
    foreach (ram[i]) ram[i] = 1'b0;
    m_init  = 1'b1;
    m_sweep = 0;
    mode    = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) rst_n = 1'b1;
      if (cyc % 150 == 0) mode = $urandom_range(0, 2);
      if (cyc == 1700) begin
        drive_rand();
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        m_init = 1'b1; m_sweep = 0; mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive_rand();
      #1;
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
